rgb2ycbcr_cfg: RTL and testbench
================================

Name: rgb2ycbcr_cfg

Overview:
Parametrised, run-time-selectable RGB-to-YCbCr converter for the video pipeline. It sits between the camera/LCD RGB source and the downstream YCbCr consumers (skin detect, binarisation, edge filters).
- Accepts any RGB input width from 4 to 8 bits per channel.
- Supports BT.601 full range, BT.601 studio range, BT.709 full range, and an RGB888 bypass mode.
- Uses rounding and saturation on all outputs.
- The mode is frame-synchronous: a change is only applied at a vsync rising edge.

Parameters:
R_W, 5, red input width (4..8)
G_W, 6, green input width (4..8)
B_W, 5, blue input width (4..8)
DEF_MODE, 2'd0, mode loaded into the active-mode register at reset

Ports:
clk  in  1  pixel clock
rst_n  in  1  reset; asynchronous, active-low
cfg_mode  in  2  requested mode: 0=BT601 full, 1=BT601 studio, 2=BT709 full, 3=bypass RGB888
pre_frame_vsync  in  1  input vsync
pre_frame_hsync  in  1  input hsync
pre_frame_de  in  1  input data enable
img_red  in  R_W  input R
img_green  in  G_W  input G
img_blue  in  B_W  input B
post_frame_vsync  out  1  vsync delayed 3 cycles
post_frame_hsync  out  1  hsync delayed 3 cycles
post_frame_de  out  1  de delayed 3 cycles
img_y  out  8  Y (R888 in bypass)
img_cb  out  8  Cb (G888 in bypass)
img_cr  out  8  Cr (B888 in bypass)
active_mode  out  2  mode currently applied

Behaviour:
- Width expansion (combinational):
  - Each channel is widened to 8 bits by MSB replication: {x, x[W-1 -: 8-W]}.
  - When W=8 the channel passes unchanged.
- Mode latch:
  - Input vsync is registered once into vs_q.
  - On pre_frame_vsync=1 with vs_q=0 (rising edge), active_mode <= cfg_mode.
  - At any other time active_mode holds, so a cfg_mode change mid-frame has no effect until the next frame.
  - active_mode resets to DEF_MODE.
- Coefficient sets. Scale is 256; offsets are pre-scaled and already include the +128 rounding term.
  - Mode 0: Y = 77R + 150G + 29B + 128. Cb = -43R - 85G + 128B + 32896. Cr = 128R - 107G - 21B + 32896.
  - Mode 1: Y = 66R + 129G + 25B + 4224. Cb = -38R - 74G + 112B + 32896. Cr = 112R - 94G - 18B + 32896.
  - Mode 2: Y = 54R + 183G + 19B + 128. Cb = -29R - 99G + 128B + 32896. Cr = 128R - 116G - 12B + 32896.
  - Mode 3: no arithmetic; the expanded R, G, B are routed to the Y, Cb, Cr lanes.
- Pipeline (fixed latency 3, one pixel per clock, no stalls):
  - S1: the 9 signed products are registered, along with the offset selection for the mode in effect.
  - S2: the three sums are formed in signed 19-bit accumulators (offset included).
  - S3: each sum is shifted >>8, then saturated: <0 gives 0, >255 gives 255. The result is registered.
  - All pixel data passes through one stage per cycle, so a mode switch takes effect on a pixel boundary.
- Sync/output:
  - vsync, hsync and de are each delayed through a 3-stage shift register.
  - img_y/cb/cr are forced to 0 whenever post_frame_de=0. Gating is on de, not hsync.
- Reset (async, any time, including mid-frame):
  - All pipeline registers, sync delay lines and outputs go to 0; active_mode goes to DEF_MODE.
  - The first valid outputs appear 3 cycles after de is asserted following reset release.
- Simultaneous events: on the vsync rising-edge cycle, the pixel entering S1 in that same cycle already uses the new cfg_mode.

Decomposition:
- Shared package rgb2ycbcr_pkg holds:
  - mode enum (MODE_601F, MODE_601S, MODE_709F, MODE_BYP)
  - the 9-coefficient and 3-offset constant sets per mode
  - ACC_W=19
- One sub-module, csc_lane: product sum → shift → saturate for one output channel, instantiated 3×.
- Width expansion and the sync delay lines stay in the top level.

Test Plan:
- Mode 0, RGB565 white (31,63,31) with de=1 → 3 cycles later Y=255, Cb=128, Cr=128; post_frame_de=1.
- Mode 0, pure red (31,0,0) → Y=77, Cb=85, Cr=255. The raw Cr sum is 65536; this checks saturation.
- Mode 1, black (0,0,0) → Y=16, Cb=128, Cr=128; white → Y=235, Cb=128, Cr=128.
- cfg_mode changes 0→3 mid-frame → outputs keep mode 0 until the next vsync rising edge. After it, input (31,63,31) → 255, 255, 255, and active_mode=3.
- de low with nonzero RGB → outputs are 0 while the delayed de is 0. Sync outputs track the inputs delayed by exactly 3 cycles.
- Assert rst_n low mid-line → all outputs are 0 immediately (asynchronous) and active_mode=DEF_MODE. After release, data matches the reference model with 3-cycle latency. Repeat with R_W=G_W=B_W=8.

Source files
------------

// File: rtl/rgb2ycbcr_pkg.sv
// Shared types and per-mode coefficient tables for the RGB-to-YCbCr converter.
// Coefficients are scaled by 256; offsets already carry the +128 rounding term.
package rgb2ycbcr_pkg;

    typedef enum logic [1:0] {
        MODE_601F = 2'd0,
        MODE_601S = 2'd1,
        MODE_709F = 2'd2,
        MODE_BYP  = 2'd3
    } mode_t;

    localparam int ACC_W = 19;

    typedef logic signed [ACC_W-1:0] acc_t;

    // [mode][lane Y/Cb/Cr][channel R/G/B]; bypass carries zeros, its data is routed around
    localparam acc_t COEF [4][3][3] = '{
        '{ '{ 19'sd77,   19'sd150,  19'sd29  },
           '{-19'sd43,  -19'sd85,   19'sd128 },
           '{ 19'sd128, -19'sd107, -19'sd21  } },
        '{ '{ 19'sd66,   19'sd129,  19'sd25  },
           '{-19'sd38,  -19'sd74,   19'sd112 },
           '{ 19'sd112, -19'sd94,  -19'sd18  } },
        '{ '{ 19'sd54,   19'sd183,  19'sd19  },
           '{-19'sd29,  -19'sd99,   19'sd128 },
           '{ 19'sd128, -19'sd116, -19'sd12  } },
        '{ '{ 19'sd0,    19'sd0,    19'sd0   },
           '{ 19'sd0,    19'sd0,    19'sd0   },
           '{ 19'sd0,    19'sd0,    19'sd0   } }
    };

    localparam acc_t OFFS [4][3] = '{
        '{ 19'sd128,  19'sd32896, 19'sd32896 },
        '{ 19'sd4224, 19'sd32896, 19'sd32896 },
        '{ 19'sd128,  19'sd32896, 19'sd32896 },
        '{ 19'sd0,    19'sd0,     19'sd0     }
    };

    function automatic acc_t widen(input logic [7:0] v);
        return acc_t'({11'b0, v});
    endfunction

endpackage

// File: rtl/rgb2ycbcr_cfg_csc_lane.sv
// One output channel: sums three registered products plus offset (S2), then
// scales down by 256 and saturates to 0..255 (S3). Bypass data rides alongside.
module csc_lane
    import rgb2ycbcr_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  acc_t       p0,
    input  acc_t       p1,
    input  acc_t       p2,
    input  acc_t       off,
    input  logic       byp,
    input  logic [7:0] byp_val,
    output logic [7:0] pix
);

    acc_t       sum_q;
    acc_t       sh;
    logic       byp_q;
    logic [7:0] val_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
            byp_q <= 1'b0;
            val_q <= '0;
        end else begin
            sum_q <= p0 + p1 + p2 + off;
            byp_q <= byp;
            val_q <= byp_val;
        end
    end

    assign sh = sum_q >>> 8;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix <= '0;
        end else if (byp_q) begin
            pix <= val_q;
        end else if (sh[ACC_W-1]) begin
            pix <= 8'd0;
        end else if (sh > 19'sd255) begin
            pix <= 8'd255;
        end else begin
            pix <= sh[7:0];
        end
    end

endmodule

// File: rtl/rgb2ycbcr_cfg.sv
// Run-time-selectable RGB-to-YCbCr converter, 3-cycle fixed latency.
// The mode is latched only on a vsync rising edge so changes land on frame boundaries.
module rgb2ycbcr_cfg
    import rgb2ycbcr_pkg::*;
#(
    parameter int         R_W      = 5,
    parameter int         G_W      = 6,
    parameter int         B_W      = 5,
    parameter logic [1:0] DEF_MODE = 2'd0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [1:0]     cfg_mode,
    input  logic           pre_frame_vsync,
    input  logic           pre_frame_hsync,
    input  logic           pre_frame_de,
    input  logic [R_W-1:0] img_red,
    input  logic [G_W-1:0] img_green,
    input  logic [B_W-1:0] img_blue,
    output logic           post_frame_vsync,
    output logic           post_frame_hsync,
    output logic           post_frame_de,
    output logic [7:0]     img_y,
    output logic [7:0]     img_cb,
    output logic [7:0]     img_cr,
    output logic [1:0]     active_mode
);

    logic [7:0] px [3];

    generate
        if (R_W == 8) begin : g_r_full
            assign px[0] = img_red;
        end else begin : g_r_exp
            assign px[0] = {img_red, img_red[R_W-1 -: 8-R_W]};
        end
        if (G_W == 8) begin : g_g_full
            assign px[1] = img_green;
        end else begin : g_g_exp
            assign px[1] = {img_green, img_green[G_W-1 -: 8-G_W]};
        end
        if (B_W == 8) begin : g_b_full
            assign px[2] = img_blue;
        end else begin : g_b_exp
            assign px[2] = {img_blue, img_blue[B_W-1 -: 8-B_W]};
        end
    endgenerate

    logic  vs_q;
    logic  vs_rise;
    mode_t active_q;
    mode_t mode_eff;

    assign vs_rise = pre_frame_vsync & ~vs_q;

    // The pixel arriving with the vsync edge already uses the new mode.
    always_comb begin
        mode_eff = active_q;
        if (vs_rise) mode_eff = mode_t'(cfg_mode);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_q     <= 1'b0;
            active_q <= mode_t'(DEF_MODE);
        end else begin
            vs_q     <= pre_frame_vsync;
            active_q <= mode_eff;
        end
    end

    assign active_mode = active_q;

    acc_t       prod   [3][3];
    acc_t       off_s1 [3];
    logic       byp_s1;
    logic [7:0] px_s1  [3];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byp_s1 <= 1'b0;
            for (int l = 0; l < 3; l++) begin
                off_s1[l] <= '0;
                px_s1[l]  <= '0;
                for (int c = 0; c < 3; c++) prod[l][c] <= '0;
            end
        end else begin
            byp_s1 <= (mode_eff == MODE_BYP);
            for (int l = 0; l < 3; l++) begin
                off_s1[l] <= OFFS[mode_eff][l];
                px_s1[l]  <= px[l];
                for (int c = 0; c < 3; c++) prod[l][c] <= COEF[mode_eff][l][c] * widen(px[c]);
            end
        end
    end

    logic [7:0] pix [3];

    generate
        for (genvar l = 0; l < 3; l++) begin : g_lane
            csc_lane u_lane (
                .clk     (clk),
                .rst_n   (rst_n),
                .p0      (prod[l][0]),
                .p1      (prod[l][1]),
                .p2      (prod[l][2]),
                .off     (off_s1[l]),
                .byp     (byp_s1),
                .byp_val (px_s1[l]),
                .pix     (pix[l])
            );
        end
    endgenerate

    logic [2:0] vs_d;
    logic [2:0] hs_d;
    logic [2:0] de_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_d <= '0;
            hs_d <= '0;
            de_d <= '0;
        end else begin
            vs_d <= {vs_d[1:0], pre_frame_vsync};
            hs_d <= {hs_d[1:0], pre_frame_hsync};
            de_d <= {de_d[1:0], pre_frame_de};
        end
    end

    assign post_frame_vsync = vs_d[2];
    assign post_frame_hsync = hs_d[2];
    assign post_frame_de    = de_d[2];

    assign img_y  = de_d[2] ? pix[0] : 8'd0;
    assign img_cb = de_d[2] ? pix[1] : 8'd0;
    assign img_cr = de_d[2] ? pix[2] : 8'd0;

endmodule

// File: tb/tb_rgb2ycbcr_cfg.sv
// Bench for rgb2ycbcr_cfg: directed vector table on an RGB565 instance plus a
// randomized scoreboard run on both RGB565 and RGB888 instances, with mid-line resets.
module tb_rgb2ycbcr_cfg;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] cfg_mode = '0;
    logic       vs = 1'b0, hs = 1'b0, de = 1'b0;
    logic [4:0] r5 = '0;
    logic [5:0] g6 = '0;
    logic [4:0] b5 = '0;
    logic [7:0] r8 = '0, g8 = '0, b8 = '0;

    logic       a_vs, a_hs, a_de, b_vs, b_hs, b_de;
    logic [7:0] a_y, a_cb, a_cr, b_y, b_cb, b_cr;
    logic [1:0] a_mode, b_mode;

    rgb2ycbcr_cfg #(.R_W(5), .G_W(6), .B_W(5), .DEF_MODE(2'd0)) dut565 (
        .clk(clk), .rst_n(rst_n), .cfg_mode(cfg_mode),
        .pre_frame_vsync(vs), .pre_frame_hsync(hs), .pre_frame_de(de),
        .img_red(r5), .img_green(g6), .img_blue(b5),
        .post_frame_vsync(a_vs), .post_frame_hsync(a_hs), .post_frame_de(a_de),
        .img_y(a_y), .img_cb(a_cb), .img_cr(a_cr), .active_mode(a_mode)
    );

    rgb2ycbcr_cfg #(.R_W(8), .G_W(8), .B_W(8), .DEF_MODE(2'd0)) dut888 (
        .clk(clk), .rst_n(rst_n), .cfg_mode(cfg_mode),
        .pre_frame_vsync(vs), .pre_frame_hsync(hs), .pre_frame_de(de),
        .img_red(r8), .img_green(g8), .img_blue(b8),
        .post_frame_vsync(b_vs), .post_frame_hsync(b_hs), .post_frame_de(b_de),
        .img_y(b_y), .img_cb(b_cb), .img_cr(b_cr), .active_mode(b_mode)
    );

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    // ---------------- reference model ----------------
    int CF [4][9] = '{
        '{ 77, 150,  29, -43, -85, 128, 128, -107, -21},
        '{ 66, 129,  25, -38, -74, 112, 112,  -94, -18},
        '{ 54, 183,  19, -29, -99, 128, 128, -116, -12},
        '{  0,   0,   0,   0,   0,   0,   0,    0,   0}
    };
    int OF [4][3] = '{
        '{ 128, 32896, 32896},
        '{4224, 32896, 32896},
        '{ 128, 32896, 32896},
        '{   0,     0,     0}
    };

    function automatic int expw(int x, int w);
        if (w == 8) return x;
        return (x << (8 - w)) | (x >> (2 * w - 8));
    endfunction

    function automatic logic [23:0] conv(int m, int r, int g, int b);
        int s;
        logic [23:0] res;
        res = '0;
        if (m == 3) return {8'(r), 8'(g), 8'(b)};
        for (int k = 0; k < 3; k++) begin
            s = CF[m][3*k] * r + CF[m][3*k+1] * g + CF[m][3*k+2] * b + OF[m][k];
            s = s >>> 8;
            if (s < 0) s = 0;
            else if (s > 255) s = 255;
            res[23 - 8*k -: 8] = 8'(s);
        end
        return res;
    endfunction

    typedef struct packed {
        logic [7:0] y, cb, cr;
        logic       vs, hs, de;
    } exp_t;

    exp_t pa [3];
    exp_t pb [3];
    int   mode_m = 0;
    logic vs_prev = 1'b0;

    initial for (int i = 0; i < 3; i++) begin pa[i] = '0; pb[i] = '0; end

    always @(posedge clk or negedge rst_n) begin
        exp_t ea, eb;
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin pa[i] = '0; pb[i] = '0; end
            mode_m  = 0;
            vs_prev = 1'b0;
        end else begin
            if (vs && !vs_prev) mode_m = int'(cfg_mode);
            vs_prev = vs;
            ea = '0; eb = '0;
            ea.vs = vs; ea.hs = hs; ea.de = de;
            eb.vs = vs; eb.hs = hs; eb.de = de;
            if (de) begin
                {ea.y, ea.cb, ea.cr} = conv(mode_m, expw(int'(r5), 5), expw(int'(g6), 6), expw(int'(b5), 5));
                {eb.y, eb.cb, eb.cr} = conv(mode_m, int'(r8), int'(g8), int'(b8));
            end
            pa[2] = pa[1]; pa[1] = pa[0]; pa[0] = ea;
            pb[2] = pb[1]; pb[1] = pb[0]; pb[0] = eb;
        end
    end

    task automatic check_one(input int id, input exp_t e, input exp_t got, input logic [1:0] gm);
        vectors++;
        if (got !== e || gm !== mode_m[1:0]) begin
            miscompares++;
            $display("FAIL scoreboard dut%0d t=%0t: got y=%0d cb=%0d cr=%0d vhd=%b%b%b mode=%0d, expected y=%0d cb=%0d cr=%0d vhd=%b%b%b mode=%0d",
                     id, $time, got.y, got.cb, got.cr, got.vs, got.hs, got.de, gm,
                     e.y, e.cb, e.cr, e.vs, e.hs, e.de, mode_m);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check_one(565, pa[2], {a_y, a_cb, a_cr, a_vs, a_hs, a_de}, a_mode);
            check_one(888, pb[2], {b_y, b_cb, b_cr, b_vs, b_hs, b_de}, b_mode);
        end
    end

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [1:0] cfg;
        bit         pulse;
        bit         den;
        int         r, g, b;
        int         ey, ecb, ecr;
        int         emode;
    } vec_t;

    vec_t tbl [8];

    task automatic reset_check(input int id);
        vectors++;
        if (a_y !== 8'd0 || a_cb !== 8'd0 || a_cr !== 8'd0 || a_vs || a_hs || a_de || a_mode !== 2'd0 ||
            b_y !== 8'd0 || b_cb !== 8'd0 || b_cr !== 8'd0 || b_vs || b_hs || b_de || b_mode !== 2'd0) begin
            miscompares++;
            $display("FAIL async_reset%0d: got a=%0d/%0d/%0d %b%b%b m%0d b=%0d/%0d/%0d %b%b%b m%0d, expected all 0 and mode 0",
                     id, a_y, a_cb, a_cr, a_vs, a_hs, a_de, a_mode, b_y, b_cb, b_cr, b_vs, b_hs, b_de, b_mode);
        end
    endtask

    initial begin
        tbl[0] = '{2'd1, 1'b1, 1'b1,  0,  0,  0,  16, 128, 128, 1};
        tbl[1] = '{2'd1, 1'b0, 1'b1, 31, 63, 31, 235, 128, 128, 1};
        tbl[2] = '{2'd0, 1'b1, 1'b1, 31, 63, 31, 255, 128, 128, 0};
        tbl[3] = '{2'd0, 1'b0, 1'b1, 31,  0,  0,  77,  85, 255, 0};
        tbl[4] = '{2'd3, 1'b0, 1'b1, 31, 63, 31, 255, 128, 128, 0};
        tbl[5] = '{2'd3, 1'b1, 1'b1, 31, 63, 31, 255, 255, 255, 3};
        tbl[6] = '{2'd2, 1'b1, 1'b1, 31,  0,  0,  54,  99, 255, 2};
        tbl[7] = '{2'd2, 1'b0, 1'b0, 31, 63, 31,   0,   0,   0, 2};

        @(posedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            cfg_mode = tbl[i].cfg;
            vs = tbl[i].pulse; hs = 1'b1; de = tbl[i].den;
            r5 = 5'(tbl[i].r); g6 = 6'(tbl[i].g); b5 = 5'(tbl[i].b);
            r8 = 8'(expw(tbl[i].r, 5)); g8 = 8'(expw(tbl[i].g, 6)); b8 = 8'(expw(tbl[i].b, 5));
            @(negedge clk);
            vs = 1'b0; hs = 1'b0; de = 1'b0;
            r5 = '0; g6 = '0; b5 = '0; r8 = '0; g8 = '0; b8 = '0;
            @(negedge clk);
            @(negedge clk);
            vectors++;
            if (int'(a_y) != tbl[i].ey || int'(a_cb) != tbl[i].ecb || int'(a_cr) != tbl[i].ecr ||
                a_de !== tbl[i].den || a_hs !== 1'b1 || a_vs !== tbl[i].pulse || int'(a_mode) != tbl[i].emode) begin
                miscompares++;
                $display("FAIL table[%0d]: got y=%0d cb=%0d cr=%0d de=%b hs=%b vs=%b mode=%0d, expected y=%0d cb=%0d cr=%0d de=%b hs=1 vs=%b mode=%0d",
                         i, a_y, a_cb, a_cr, a_de, a_hs, a_vs, a_mode,
                         tbl[i].ey, tbl[i].ecb, tbl[i].ecr, tbl[i].den, tbl[i].pulse, tbl[i].emode);
            end
        end

        // randomized traffic with two asynchronous mid-line resets
        for (int i = 0; i < 600; i++) begin
            if (i == 200 || i == 420) begin
                de = 1'b1; hs = 1'b1;
                @(posedge clk);
                #2 rst_n = 1'b0;
                #1 reset_check(i);
                @(negedge clk);
                @(negedge clk);
                rst_n = 1'b1;
            end
            vs = ($urandom_range(0, 24) == 0);
            hs = 1'($urandom);
            de = ($urandom_range(0, 3) != 0);
            cfg_mode = 2'($urandom);
            r5 = 5'($urandom); g6 = 6'($urandom); b5 = 5'($urandom);
            r8 = 8'($urandom); g8 = 8'($urandom); b8 = 8'($urandom);
            @(negedge clk);
        end

        vs = 1'b0; hs = 1'b0; de = 1'b0;
        repeat (4) @(negedge clk);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
